// File: rtl/cpu6_trap_ctrl_if.sv
// Bundles the pipeline/CSR-facing signals of the cpu6 machine-mode trap controller.
// master = pipeline/CSR side, slave = trap controller.
interface cpu6_trap_ctrl_if #(
    parameter int XLEN     = 32,
    parameter int NUM_EXCP = 4,
    parameter int NUM_IRQ  = 12
);
    logic                pipe_valid;
    logic [XLEN-1:0]     excp_pc;
    logic [NUM_EXCP-1:0] excp_vec;
    logic [XLEN-1:0]     excp_tval;
    logic [NUM_IRQ-1:0]  irq_vec;
    logic [NUM_IRQ-1:0]  csr_mie;
    logic [XLEN-1:0]     csr_mtvec;
    logic [XLEN-1:0]     csr_mepc;
    logic                mret;

    logic                excp_flush_pc_ena;
    logic [XLEN-1:0]     excp_flush_pc;
    logic                excp_mepc_ena;
    logic [XLEN-1:0]     excp_mepc;
    logic                excp_mcause_ena;
    logic [XLEN-1:0]     excp_mcause;
    logic [XLEN-1:0]     excp_mtval;
    logic                mstatus_mie;
    logic                mstatus_mpie;
    logic                trap_busy;

    modport master (
        output pipe_valid, excp_pc, excp_vec, excp_tval, irq_vec, csr_mie,
               csr_mtvec, csr_mepc, mret,
        input  excp_flush_pc_ena, excp_flush_pc, excp_mepc_ena, excp_mepc,
               excp_mcause_ena, excp_mcause, excp_mtval, mstatus_mie,
               mstatus_mpie, trap_busy
    );

    modport slave (
        input  pipe_valid, excp_pc, excp_vec, excp_tval, irq_vec, csr_mie,
               csr_mtvec, csr_mepc, mret,
        output excp_flush_pc_ena, excp_flush_pc, excp_mepc_ena, excp_mepc,
               excp_mcause_ena, excp_mcause, excp_mtval, mstatus_mie,
               mstatus_mpie, trap_busy
    );
endinterface

// File: rtl/cpu6_trap_ctrl.sv
// Machine-mode trap controller: prioritises exceptions/interrupts/mret, owns MIE/MPIE, redirects fetch.
// Define CPU6_TRAP_VECTORED_EN to enable vectored interrupt targets when mtvec[1:0]==2'b01.
module cpu6_trap_ctrl #(
    parameter int XLEN     = 32,
    parameter int NUM_EXCP = 4,
    parameter int NUM_IRQ  = 12
) (
    input logic             clk,
    input logic             reset,
    cpu6_trap_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRAP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_IRQ-1:0]  r_irq_q;
    logic                r_mie;
    logic                r_mpie;
    logic                r_flush_ena;
    logic [XLEN-1:0]     r_flush_pc;
    logic                r_mepc_ena;
    logic [XLEN-1:0]     r_mepc;
    logic                r_mcause_ena;
    logic [XLEN-1:0]     r_mcause;
    logic [XLEN-1:0]     r_mtval;

    logic [XLEN-1:0]     w_excp_code;
    logic [XLEN-1:0]     w_irq_code;
    logic [XLEN-1:0]     w_irq_cause;
    logic [XLEN-1:0]     w_base;
    logic [XLEN-1:0]     w_irq_target;
    logic                w_take_excp;
    logic                w_take_irq;
    logic                w_take_mret;

    // Winner selection and target computation; exception is lowest index, interrupt is highest.
    always_comb begin
        w_excp_code = '0;
        for (int i = NUM_EXCP - 1; i >= 0; i--) begin
            if (bus.excp_vec[i]) w_excp_code = XLEN'(i);
        end
        w_irq_code = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (r_irq_q[i]) w_irq_code = XLEN'(i);
        end
        w_irq_cause            = w_irq_code;
        w_irq_cause[XLEN-1]    = 1'b1;
        w_base                 = bus.csr_mtvec & ~XLEN'(3);
`ifdef CPU6_TRAP_VECTORED_EN
        w_irq_target = (bus.csr_mtvec[1:0] == 2'b01) ? (w_base + (w_irq_code << 2)) : w_base;
`else
        w_irq_target = w_base;
`endif
    end

    // Next-state logic: only IDLE accepts requests; TRAP and HOLD step through unconditionally.
    always_comb begin
        w_next_state = r_state;
        w_take_excp  = 1'b0;
        w_take_irq   = 1'b0;
        w_take_mret  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.pipe_valid) begin
                    if (|bus.excp_vec) begin
                        w_take_excp = 1'b1;
                    end else if ((|r_irq_q) && r_mie) begin
                        w_take_irq = 1'b1;
                    end else if (bus.mret) begin
                        w_take_mret = 1'b1;
                    end
                end
                if (w_take_excp || w_take_irq || w_take_mret) w_next_state = TRAP;
            end
            TRAP:    w_next_state = HOLD;
            HOLD:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_irq_q      <= '0;
            r_mie        <= 1'b0;
            r_mpie       <= 1'b0;
            r_flush_ena  <= 1'b0;
            r_flush_pc   <= '0;
            r_mepc_ena   <= 1'b0;
            r_mepc       <= '0;
            r_mcause_ena <= 1'b0;
            r_mcause     <= '0;
            r_mtval      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_irq_q      <= bus.irq_vec & bus.csr_mie;
            r_flush_ena  <= 1'b0;
            r_mepc_ena   <= 1'b0;
            r_mcause_ena <= 1'b0;
            if (w_take_excp || w_take_irq) begin
                r_flush_ena  <= 1'b1;
                r_mepc_ena   <= 1'b1;
                r_mcause_ena <= 1'b1;
                r_mepc       <= bus.excp_pc;
                r_mcause     <= w_take_excp ? w_excp_code : w_irq_cause;
                r_mtval      <= w_take_excp ? bus.excp_tval : '0;
                r_flush_pc   <= w_take_excp ? w_base : w_irq_target;
                r_mpie       <= r_mie;
                r_mie        <= 1'b0;
            end else if (w_take_mret) begin
                r_flush_ena  <= 1'b1;
                r_flush_pc   <= bus.csr_mepc;
                r_mie        <= r_mpie;
                r_mpie       <= 1'b1;
            end
        end
    end

    assign bus.excp_flush_pc_ena = r_flush_ena;
    assign bus.excp_flush_pc     = r_flush_pc;
    assign bus.excp_mepc_ena     = r_mepc_ena;
    assign bus.excp_mepc         = r_mepc;
    assign bus.excp_mcause_ena   = r_mcause_ena;
    assign bus.excp_mcause       = r_mcause;
    assign bus.excp_mtval        = r_mtval;
    assign bus.mstatus_mie       = r_mie;
    assign bus.mstatus_mpie      = r_mpie;
    assign bus.trap_busy         = (r_state != IDLE);

endmodule
